// File: rtl/spi_adc_reader.sv
// ---------------------------------------------------------------------------
// spi_adc_reader
//
// SPI master that periodically reads a 16-bit serial ADC (conversion starts
// on cs_n fall, data shifted MSB first on sclk falling edges) and presents
// each captured sample on an AXI-Stream master output.
//
// Ports:
//   mclk          in   master clock (50 MHz domain)
//   rst           in   synchronous active-high reset
//   en            in   enable; low aborts the current frame, stops sampling
//   m_axis_valid  out  sample available
//   m_axis_ready  in   downstream accepts the sample
//   m_axis_data   out  captured sample, MSB = first bit received
//   cs_n          out  ADC chip select, active low
//   sclk          out  SPI clock, idles high
//   miso          in   ADC serial data
//   overrun       out  one-cycle pulse: a sample was dropped
//
// Build option:
//   ADC_OVERSAMPLE_AVG_EN  when defined, four consecutive frames are summed
//                          and their truncated mean is published instead of
//                          every individual frame.
//
// All outputs are registered.
// ---------------------------------------------------------------------------
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | cs_n high, waiting for the sample-period tick
// START   | cs_n low, first half sclk period before the first fall
// XMIT    | toggling sclk every half period, capturing on each rise
// FINISH  | last rise done, sclk held high for half a period before cs_n
// PUBLISH | cs_n high again; captured frame handed to the output stage
//
module spi_adc_reader #(
    parameter int unsigned MCLK_CYCLES_PER_SAMPLE        = 200,
    parameter int unsigned MCLK_CYCLES_PER_SPI_CLK_CYCLE = 8,
    parameter int unsigned DATA_BITS                     = 16
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 m_axis_valid,
    input  logic                 m_axis_ready,
    output logic [DATA_BITS-1:0] m_axis_data,
    output logic                 cs_n,
    output logic                 sclk,
    input  logic                 miso,
    output logic                 overrun
);

    localparam int unsigned HALF_PERIOD = MCLK_CYCLES_PER_SPI_CLK_CYCLE / 2;

    localparam int unsigned SAMPLE_W = $clog2(MCLK_CYCLES_PER_SAMPLE);
    localparam int unsigned HALF_W   = $clog2(MCLK_CYCLES_PER_SPI_CLK_CYCLE);
    localparam int unsigned BIT_W    = $clog2(DATA_BITS);

    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(MCLK_CYCLES_PER_SAMPLE - 1);
    localparam logic [HALF_W-1:0]   HALF_LOAD   = HALF_W'(HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_XMIT    = 3'd2;
    localparam logic [2:0] ST_FINISH  = 3'd3;
    localparam logic [2:0] ST_PUBLISH = 3'd4;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [2:0]           state_q,      state_d;
    logic [SAMPLE_W-1:0]  sample_cnt_q, sample_cnt_d;
    logic [HALF_W-1:0]    half_q,       half_d;
    logic [BIT_W-1:0]     bit_q,        bit_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 cs_n_q,       cs_n_d;
    logic                 sclk_q,       sclk_d;
    logic                 valid_q,      valid_d;
    logic [DATA_BITS-1:0] data_q,       data_d;
    logic                 overrun_q,    overrun_d;

`ifdef ADC_OVERSAMPLE_AVG_EN
    logic [DATA_BITS+1:0] acc_q,        acc_d;
    logic [1:0]           frame_cnt_q,  frame_cnt_d;
    logic [DATA_BITS+1:0] acc_sum;
`endif

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic                 tick;
    logic                 half_done;
    logic                 frame_done;
    logic                 publish;
    logic [DATA_BITS-1:0] pub_data;

    assign tick      = en && (sample_cnt_q == SAMPLE_LAST);
    assign half_done = (half_q == '0);

    // Sample-period counter: free-runs 0..N-1 while enabled, parked at 0
    // otherwise so re-enabling always gives a full period before the frame.
    always_comb begin
        sample_cnt_d = sample_cnt_q;
        if (!en) begin
            sample_cnt_d = '0;
        end else if (sample_cnt_q == SAMPLE_LAST) begin
            sample_cnt_d = '0;
        end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM
    // half_q is a down-counter timing each half sclk period; every terminal
    // count either toggles sclk or advances the state.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_START;
                    cs_n_d  = 1'b0;
                    half_d  = HALF_LOAD;
                    bit_d   = '0;
                    shift_d = '0;
                end
            end

            ST_START: begin
                if (half_done) begin
                    sclk_d  = 1'b0;
                    half_d  = HALF_LOAD;
                    state_d = ST_XMIT;
                end else begin
                    half_d = half_q - 1'b1;
                end
            end

            ST_XMIT: begin
                if (half_done) begin
                    half_d = HALF_LOAD;
                    if (!sclk_q) begin
                        // Capture on the same edge that raises sclk: miso has
                        // been stable since the previous fall.
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[DATA_BITS-2:0], miso};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_FINISH;
                        end
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    half_d = half_q - 1'b1;
                end
            end

            ST_FINISH: begin
                if (half_done) begin
                    cs_n_d  = 1'b1;
                    state_d = ST_PUBLISH;
                end else begin
                    half_d = half_q - 1'b1;
                end
            end

            ST_PUBLISH: begin
                state_d    = ST_IDLE;
                frame_done = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase

        // Disable overrides everything: drop the frame, release the bus.
        if (!en) begin
            state_d    = ST_IDLE;
            cs_n_d     = 1'b1;
            sclk_d     = 1'b1;
            half_d     = '0;
            bit_d      = '0;
            shift_d    = '0;
            frame_done = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Frame-to-output selection
    // -----------------------------------------------------------------------
`ifdef ADC_OVERSAMPLE_AVG_EN
    // Accumulate four frames; the fourth publishes the sum divided by four
    // (truncated) and restarts the group.
    assign acc_sum  = acc_q + {2'b00, shift_q};
    assign pub_data = acc_sum[DATA_BITS+1:2];

    always_comb begin
        acc_d       = acc_q;
        frame_cnt_d = frame_cnt_q;
        publish     = 1'b0;
        if (frame_done) begin
            if (frame_cnt_q == 2'd3) begin
                publish     = 1'b1;
                acc_d       = '0;
                frame_cnt_d = '0;
            end else begin
                acc_d       = acc_sum;
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        if (!en) begin
            acc_d       = '0;
            frame_cnt_d = '0;
        end
    end
`else
    assign publish  = frame_done;
    assign pub_data = shift_q;
`endif

    // -----------------------------------------------------------------------
    // AXI-Stream output stage
    // A publish into a slot that is being emptied this same cycle reloads
    // without a valid gap; a publish into a stalled full slot is dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = 1'b0;
        if (publish) begin
            if (!valid_q || m_axis_ready) begin
                data_d  = pub_data;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && m_axis_ready) begin
            valid_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            half_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b1;
            valid_q      <= 1'b0;
            data_q       <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            half_q       <= half_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef ADC_OVERSAMPLE_AVG_EN
    always_ff @(posedge mclk) begin
        if (rst) begin
            acc_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            acc_q       <= acc_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end
`endif

    assign cs_n         = cs_n_q;
    assign sclk         = sclk_q;
    assign m_axis_valid = valid_q;
    assign m_axis_data  = data_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_spi_adc_reader.sv
// ---------------------------------------------------------------------------
// tb_spi_adc_reader
//
// Self-checking bench for spi_adc_reader. An ADC model shifts queued words
// out on sclk falls; the expected output for each frame is pushed onto a
// scoreboard queue when the model starts driving it and is popped whenever
// the DUT completes an AXI-Stream handshake.
// ---------------------------------------------------------------------------
module tb_spi_adc_reader;

`ifdef ADC_OVERSAMPLE_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic        mclk = 1'b0;
    logic        rst;
    logic        en;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic [15:0] m_axis_data;
    logic        cs_n;
    logic        sclk;
    logic        miso;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    always #10 mclk = ~mclk;

    spi_adc_reader #(
        .MCLK_CYCLES_PER_SAMPLE       (200),
        .MCLK_CYCLES_PER_SPI_CLK_CYCLE(8),
        .DATA_BITS                    (16)
    ) dut (
        .mclk        (mclk),
        .rst         (rst),
        .en          (en),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready),
        .m_axis_data (m_axis_data),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .miso        (miso),
        .overrun     (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // -----------------------------------------------------------------------
    // ADC model + scoreboard push
    // -----------------------------------------------------------------------
    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_data;
        bit          expect_out;
    } frame_t;

    frame_t      adc_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] cur_word = 16'h0;
    int          bit_idx  = -1;

    always @(negedge cs_n) begin
        frame_t f;
        if (adc_q.size() > 0) begin
            f = adc_q.pop_front();
        end else begin
            f.word       = 16'h0000;
            f.exp_data   = 16'h0000;
            f.expect_out = !AVG;
        end
        cur_word = f.word;
        bit_idx  = 15;
        if (f.expect_out) exp_q.push_back(f.exp_data);
    end

    always @(negedge sclk) begin
        if (!cs_n && bit_idx >= 0) begin
            miso = cur_word[bit_idx];
            bit_idx--;
        end
    end

    // -----------------------------------------------------------------------
    // Monitor (samples on the falling mclk edge)
    // -----------------------------------------------------------------------
    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;
    int cs_low_cnt = 0, last_cs_low = 0, rise_cnt = 0, last_rises = 0;
    int cs_falls = 0, cs_rises = 0, fall_cyc = 0;
    int overrun_cnt = 0, valid_rises = 0, valid_rise_cyc = 0, prev_valid_rise_cyc = 0;

    always @(negedge mclk) begin
        if (m_axis_valid && m_axis_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample actual=0x%0h required=none", m_axis_data);
            end else begin
                check("sample_data", 32'(m_axis_data), 32'(exp_q.pop_front()));
            end
        end
        if (!cs_n) begin
            if (prev_cs) begin
                cs_low_cnt = 0;
                rise_cnt   = 0;
                fall_cyc   = cyc;
                cs_falls++;
            end
            cs_low_cnt++;
            if (sclk && !prev_sclk) rise_cnt++;
        end else if (!prev_cs) begin
            last_cs_low = cs_low_cnt;
            last_rises  = rise_cnt;
            cs_rises++;
        end
        if (overrun) overrun_cnt++;
        if (m_axis_valid && !prev_valid) begin
            valid_rises++;
            prev_valid_rise_cyc = valid_rise_cyc;
            valid_rise_cyc      = cyc;
        end
        prev_cs    = cs_n;
        prev_sclk  = sclk;
        prev_valid = m_axis_valid;
    end

    // -----------------------------------------------------------------------
    // Bounded waits (return just after a falling edge)
    // -----------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic wait_valid_rise(input int budget, input string name);
        int start = valid_rises;
        int n = 0;
        while (valid_rises == start && n < budget) begin
            @(negedge mclk); #1; n++;
        end
        check(name, 32'(valid_rises != start), 32'd1);
    endtask

    task automatic wait_cs_fall(input int budget, input string name);
        int start = cs_falls;
        int n = 0;
        while (cs_falls == start && n < budget) begin
            @(negedge mclk); #1; n++;
        end
        check(name, 32'(cs_falls != start), 32'd1);
    endtask

    task automatic wait_cs_rise(input int budget, input string name);
        int start = cs_rises;
        int n = 0;
        while (cs_rises == start && n < budget) begin
            @(negedge mclk); #1; n++;
        end
        check(name, 32'(cs_rises != start), 32'd1);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int c0, vr0, ov0, r, n;
        logic prev_s;

        vecs[0] = '{16'hA5C3, 16'hA5C3};
        vecs[1] = '{16'h0001, 16'h0001};
        vecs[2] = '{16'hFFFF, 16'hFFFF};
        vecs[3] = '{16'h8000, 16'h8000};
        vecs[4] = '{16'h0000, 16'h0000};
        vecs[5] = '{16'h5A5A, 16'h5A5A};

        rst = 1'b1; en = 1'b0; m_axis_ready = 1'b1; miso = 1'b0;
        cycles(3);
        @(negedge mclk);
        check("reset_cs_n",    32'(cs_n),         32'd1);
        check("reset_sclk",    32'(sclk),         32'd1);
        check("reset_valid",   32'(m_axis_valid), 32'd0);
        check("reset_data",    32'(m_axis_data),  32'd0);
        check("reset_overrun", 32'(overrun),      32'd0);
        cycles(1);
        rst = 1'b0;
        cycles(2);

`ifdef ADC_OVERSAMPLE_AVG_EN
        // Four frames averaged into one output.
        for (int i = 0; i < 4; i++) begin
            adc_q.push_back('{16'h1000 + 16'(2 * i + (i == 3 ? 1 : 0)), 16'h0, 1'b0});
        end
        exp_q.push_back(16'h1003);
        vr0 = valid_rises;
        en  = 1'b1;
        wait_valid_rise(1100, "avg_valid_timeout");
        cycles(60);
        check("avg_single_output", 32'(valid_rises - vr0), 32'd1);
        en = 1'b0;
        cycles(5);

        // Reset after two frames discards the partial sum.
        adc_q.push_back('{16'h1111, 16'h0, 1'b0});
        adc_q.push_back('{16'h1111, 16'h0, 1'b0});
        en = 1'b1;
        wait_cs_rise(450, "avg_frame1_timeout");
        wait_cs_rise(450, "avg_frame2_timeout");
        cycles(5);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) adc_q.push_back('{16'h0004, 16'h0, 1'b0});
        exp_q.push_back(16'h0004);
        cycles(1);
        rst = 1'b0;
        vr0 = valid_rises;
        wait_valid_rise(1100, "avg_after_rst_timeout");
        check("avg_after_rst_data", 32'(m_axis_data), 32'h0004);
        check("avg_after_rst_single", 32'(valid_rises - vr0), 32'd1);
        cycles(2);
        en = 1'b0;
        cycles(5);
`else
        // Continuous run, ready held high.
        for (int i = 0; i < 6; i++) adc_q.push_back('{vecs[i].word, vecs[i].exp_data, 1'b1});
        ov0 = overrun_cnt;
        en  = 1'b1;
        c0  = cyc;
        for (int i = 0; i < 6; i++) begin
            wait_valid_rise(450, "valid_timeout");
            check("cs_low_cycles", 32'(last_cs_low), 32'd132);
            check("sclk_rises", 32'(last_rises), 32'd16);
            if (i > 0) check("valid_spacing", 32'(valid_rise_cyc - prev_valid_rise_cyc), 32'd200);
            else       check("first_valid_latency", 32'(valid_rise_cyc - c0), 32'd333);
            @(negedge mclk);
            check("valid_one_cycle", 32'(m_axis_valid), 32'd0);
        end
        check("no_overrun_continuous", 32'(overrun_cnt - ov0), 32'd0);
        cycles(1);
        en = 1'b0;
        cycles(5);

        // Ready low across two frames: second sample is dropped.
        m_axis_ready = 1'b0;
        ov0 = overrun_cnt;
        adc_q.push_back('{16'h1111, 16'h1111, 1'b1});
        adc_q.push_back('{16'h2222, 16'h2222, 1'b0});
        en = 1'b1;
        wait_valid_rise(450, "stall_valid_timeout");
        n = 0;
        while (overrun_cnt == ov0 && n < 300) begin
            @(negedge mclk); #1; n++;
        end
        check("stall_overrun_seen", 32'(overrun_cnt - ov0), 32'd1);
        check("stall_data_kept", 32'(m_axis_data), 32'h1111);
        check("stall_valid_held", 32'(m_axis_valid), 32'd1);
        @(negedge mclk);
        check("overrun_one_cycle", 32'(overrun), 32'd0);
        cycles(3);
        m_axis_ready = 1'b1;
        @(negedge mclk);
        @(negedge mclk);
        check("stall_release_valid_drop", 32'(m_axis_valid), 32'd0);
        check("stall_overrun_total", 32'(overrun_cnt - ov0), 32'd1);
        cycles(1);
        en = 1'b0;
        cycles(5);

        // Ready asserted exactly in the publish cycle of frame 2.
        m_axis_ready = 1'b0;
        ov0 = overrun_cnt;
        adc_q.push_back('{16'h1111, 16'h1111, 1'b1});
        adc_q.push_back('{16'h2222, 16'h2222, 1'b1});
        en = 1'b1;
        wait_valid_rise(450, "coinc_valid_timeout");
        wait_cs_fall(300, "coinc_frame2_timeout");
        n = 0;
        do begin
            @(posedge mclk); #1; n++;
        end while (cs_n == 1'b0 && n < 300);
        check("coinc_publish_reached", 32'(cs_n), 32'd1);
        m_axis_ready = 1'b1;
        @(posedge mclk); #1;
        m_axis_ready = 1'b0;
        check("coinc_no_valid_gap", 32'(m_axis_valid), 32'd1);
        check("coinc_new_data", 32'(m_axis_data), 32'h2222);
        check("coinc_no_overrun", 32'(overrun_cnt - ov0), 32'd0);
        cycles(2);
        m_axis_ready = 1'b1;
        cycles(2);
        en = 1'b0;
        cycles(5);

        // en dropped after the 7th sclk rise, then re-enabled.
        vr0 = valid_rises;
        adc_q.push_back('{16'h3C3C, 16'h3C3C, 1'b0});
        adc_q.push_back('{16'h9669, 16'h9669, 1'b1});
        en = 1'b1;
        r = 0; n = 0; prev_s = sclk;
        while (r < 7 && n < 400) begin
            @(posedge mclk); #1; n++;
            if (!cs_n && sclk && !prev_s) r++;
            prev_s = sclk;
        end
        check("abort_rise7_reached", 32'(r), 32'd7);
        en = 1'b0;
        @(posedge mclk); #1;
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd1);
        cycles(200);
        check("abort_no_valid", 32'(valid_rises - vr0), 32'd0);
        en = 1'b1;
        c0 = cyc;
        wait_cs_fall(250, "reenable_frame_timeout");
        check("reenable_delay", 32'(fall_cyc - c0), 32'd200);
        wait_valid_rise(200, "reenable_valid_timeout");
        check("reenable_cs_low", 32'(last_cs_low), 32'd132);
        cycles(1);
        en = 1'b0;
        cycles(5);

        // rst mid-frame loses the pending sample.
        m_axis_ready = 1'b0;
        adc_q.push_back('{16'h4321, 16'h4321, 1'b1});
        adc_q.push_back('{16'h0F0F, 16'h0F0F, 1'b0});
        en = 1'b1;
        wait_valid_rise(450, "rstmid_valid_timeout");
        check("rstmid_pending_data", 32'(m_axis_data), 32'h4321);
        wait_cs_fall(300, "rstmid_frame_timeout");
        cycles(20);
        rst = 1'b1;
        en  = 1'b0;
        @(posedge mclk); #1;
        check("rstmid_cs_n",  32'(cs_n),         32'd1);
        check("rstmid_sclk",  32'(sclk),         32'd1);
        check("rstmid_valid", 32'(m_axis_valid), 32'd0);
        check("rstmid_data",  32'(m_axis_data),  32'd0);
        exp_q.delete();
        rst = 1'b0;
        m_axis_ready = 1'b1;
        cycles(5);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
